// File: rtl/wb_pdm_ctrl.sv
// wb_pdm_ctrl: Wishbone B4 pipelined slave sequencing PDM level ramps.
// Define WB_PDM_CTRL_IRQ_EN to enable the DONE flag and settle interrupt.
module wb_pdm_ctrl #(
   parameter int CHANNELS        = 4,
   parameter int BIT_RESOLUTION  = 8,
   parameter int PRESCALER_WIDTH = 16
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_ni,
   input  logic                               wb_cyc_i,
   input  logic                               wb_stb_i,
   input  logic                               wb_we_i,
   input  logic [3:0]                         wb_adr_i,
   input  logic [31:0]                        wb_dat_i,
   output logic [31:0]                        wb_dat_o,
   output logic                               wb_ack_o,
   output logic                               wb_stall_o,
   output logic [CHANNELS*BIT_RESOLUTION-1:0] pdm_dat_o,
   output logic [CHANNELS-1:0]                pdm_stb_o,
   output logic                               irq_o
);
   localparam int BR = BIT_RESOLUTION;
   localparam int PW = PRESCALER_WIDTH;
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SWEEP = 1'b1;

   localparam logic [3:0] A_CTRL = 4'd8;
   localparam logic [3:0] A_PRE  = 4'd9;
   localparam logic [3:0] A_STEP = 4'd10;
   localparam logic [3:0] A_STAT = 4'd11;

   logic [BR-1:0]       tgt_q [CHANNELS];
   logic [BR-1:0]       tgt_d [CHANNELS];
   logic [BR-1:0]       cur_q [CHANNELS];
   logic [BR-1:0]       cur_d [CHANNELS];
   logic                en_q, en_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [PW-1:0]       cnt_q, cnt_d;
   logic [BR-1:0]       step_q, step_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [0:0]          state_q, state_d;
   logic                ack_q, ack_d;
   logic [31:0]         dat_q, dat_d;
   logic [CHANNELS-1:0] stb_q, stb_d;
   logic [CHANNELS-1:0] busy;
   logic [31:0]         rdata;
   logic                strobe, wr;

   logic [BR-1:0]        ck, tk, nk;
   logic [BR:0]          sum;
   logic signed [BR+1:0] diff;

`ifdef WB_PDM_CTRL_IRQ_EN
   logic                ie_q, ie_d;
   logic                done_q, done_d;
   logic                fired_q, fired_d;
   logic                sweep_end;
   logic [CHANNELS-1:0] busy_nxt;
`else
   logic ie_q, done_q;
   assign ie_q   = 1'b0;
   assign done_q = 1'b0;
`endif

   logic unused_dat;
   assign unused_dat = ^wb_dat_i;

   assign strobe     = wb_cyc_i & wb_stb_i;
   assign wr         = strobe & wb_we_i;
   assign wb_stall_o = 1'b0;
   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign pdm_stb_o  = stb_q;
   assign irq_o      = done_q & ie_q;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         busy[i] = (cur_q[i] != tgt_q[i]);
         pdm_dat_o[i*BR +: BR] = cur_q[i];
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wb_adr_i == 4'(i)) rdata[BR-1:0] = tgt_q[i];
      end
      case (wb_adr_i)
         A_CTRL: rdata[1:0] = {ie_q, en_q};
         A_PRE:  rdata[PW-1:0] = pre_q;
         A_STEP: rdata[BR-1:0] = step_q;
         A_STAT: begin
            rdata[CHANNELS-1:0] = busy;
            rdata[31] = done_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      tgt_d   = tgt_q;
      cur_d   = cur_q;
      en_d    = en_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      idx_d   = idx_q;
      state_d = state_q;
      ack_d   = strobe;
      dat_d   = (strobe && !wb_we_i) ? rdata : '0;
      stb_d   = '0;

      if (wr) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wb_adr_i == 4'(i)) tgt_d[i] = wb_dat_i[BR-1:0];
         end
         if (wb_adr_i == A_CTRL) en_d = wb_dat_i[0];
         if (wb_adr_i == A_PRE) pre_d = wb_dat_i[PW-1:0];
         if (wb_adr_i == A_STEP) step_d = wb_dat_i[BR-1:0];
      end

      // target is taken after the bus write so a same-edge write is honoured
      ck   = cur_q[idx_q];
      tk   = tgt_d[idx_q];
      sum  = {1'b0, ck} + {1'b0, step_q};
      diff = $signed({2'b00, ck}) - $signed({2'b00, step_q});
      if (step_q == '0) begin
         nk = tk;
      end else if (ck < tk) begin
         nk = (sum > {1'b0, tk}) ? tk : sum[BR-1:0];
      end else begin
         nk = (diff < $signed({2'b00, tk})) ? tk : diff[BR-1:0];
      end

      unique case (state_q)
         S_IDLE: begin
            if (en_q) begin
               if (cnt_q == '0) begin
                  cnt_d   = pre_q;
                  idx_d   = '0;
                  state_d = S_SWEEP;
               end else begin
                  cnt_d = cnt_q - PW'(1);
               end
            end
         end
         S_SWEEP: begin
            if (ck != tk) begin
               cur_d[idx_q] = nk;
               stb_d[idx_q] = 1'b1;
            end
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < CHANNELS; i++) begin
            tgt_q[i] <= '0;
            cur_q[i] <= '0;
         end
         en_q    <= 1'b0;
         pre_q   <= '0;
         cnt_q   <= '0;
         step_q  <= '0;
         idx_q   <= '0;
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         stb_q   <= '0;
      end else begin
         tgt_q   <= tgt_d;
         cur_q   <= cur_d;
         en_q    <= en_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         stb_q   <= stb_d;
      end
   end

`ifdef WB_PDM_CTRL_IRQ_EN
   always_comb begin
      ie_d      = ie_q;
      done_d    = done_q;
      fired_d   = fired_q | (|stb_d);
      sweep_end = (state_q == S_SWEEP) && (idx_q == LAST);
      for (int i = 0; i < CHANNELS; i++) begin
         busy_nxt[i] = (cur_d[i] != tgt_d[i]);
      end
      if (wr && wb_adr_i == A_CTRL) ie_d = wb_dat_i[1];
      if (wr && wb_adr_i == A_STAT && wb_dat_i[31]) done_d = 1'b0;
      // a settling sweep beats a simultaneous clear
      if (sweep_end) begin
         if (fired_d && busy_nxt == '0) done_d = 1'b1;
         fired_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         ie_q    <= 1'b0;
         done_q  <= 1'b0;
         fired_q <= 1'b0;
      end else begin
         ie_q    <= ie_d;
         done_q  <= done_d;
         fired_q <= fired_d;
      end
   end
`endif

endmodule

// File: tb/tb_wb_pdm_ctrl.sv
// tb_wb_pdm_ctrl: randomized and directed checks of wb_pdm_ctrl
// against a behavioural sweep model.
module tb_wb_pdm_ctrl;
   localparam int CH = 4;
   localparam int BR = 8;
`ifdef WB_PDM_CTRL_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]     adr = '0;
   logic [31:0]    dat = '0;
   logic [31:0]    dat_o;
   logic           ack, stall, irq;
   logic [CH*BR-1:0] pdm_dat;
   logic [CH-1:0]  pdm_stb;

   int n_tests = 0;
   int n_fail  = 0;

   wb_pdm_ctrl #(.CHANNELS(CH), .BIT_RESOLUTION(BR), .PRESCALER_WIDTH(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
      .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o),
      .wb_ack_o(ack), .wb_stall_o(stall), .pdm_dat_o(pdm_dat),
      .pdm_stb_o(pdm_stb), .irq_o(irq)
   );

   always #5 clk = ~clk;

   // model state: sweep position -1 means idle
   int m_tgt [CH];
   int m_cur [CH];
   int m_en, m_ie, m_pre, m_step, m_cnt, m_pos, m_done, m_fired;
   int m_ack, m_stb;
   logic [31:0] m_dat;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < CH; i++) begin
         m_tgt[i] = 0;
         m_cur[i] = 0;
      end
      m_en = 0; m_ie = 0; m_pre = 0; m_step = 0; m_cnt = 0;
      m_pos = -1; m_done = 0; m_fired = 0; m_ack = 0; m_stb = 0;
      m_dat = '0;
   endfunction

   function automatic logic [31:0] rd_reg(int a);
      logic [31:0] r = '0;
      if (a < CH) r = m_tgt[a];
      else if (a == 8) r = m_en | (m_ie << 1);
      else if (a == 9) r = m_pre;
      else if (a == 10) r = m_step;
      else if (a == 11) begin
         for (int i = 0; i < CH; i++)
            if (m_cur[i] != m_tgt[i]) r[i] = 1'b1;
         r[31] = (m_done != 0);
      end
      return r;
   endfunction

   function automatic void model_step();
      bit s = cyc && stb;
      bit w = s && we;
      int a = int'(adr);
      logic [31:0] d = dat;
      int k, c, t, n;
      bit last = 0;
      bit settled;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_ack = s;
      m_dat = (s && !we) ? rd_reg(a) : 32'h0;
      m_stb = 0;
      if (m_pos >= 0) begin
         k = m_pos;
         c = m_cur[k];
         t = (w && a == k) ? int'(d[BR-1:0]) : m_tgt[k];
         if (c != t) begin
            if (m_step == 0) n = t;
            else if (c < t) n = (c + m_step > t) ? t : c + m_step;
            else n = (c - m_step < t) ? t : c - m_step;
            m_cur[k] = n;
            m_stb = 1 << k;
            m_fired = 1;
         end
         last = (k == CH - 1);
         m_pos = last ? -1 : k + 1;
      end else if (m_en != 0) begin
         if (m_cnt == 0) begin
            m_cnt = m_pre;
            m_pos = 0;
         end else begin
            m_cnt--;
         end
      end
      if (w) begin
         if (a < CH) m_tgt[a] = int'(d[BR-1:0]);
         else if (a == 8) begin
            m_en = int'(d[0]);
            if (IRQ) m_ie = int'(d[1]);
         end
         else if (a == 9) m_pre = int'(d[15:0]);
         else if (a == 10) m_step = int'(d[BR-1:0]);
         else if (a == 11 && IRQ && d[31]) m_done = 0;
      end
      if (IRQ && last) begin
         settled = 1;
         for (int i = 0; i < CH; i++)
            if (m_cur[i] != m_tgt[i]) settled = 0;
         if (settled && m_fired != 0) m_done = 1;
         m_fired = 0;
      end
   endfunction

   function automatic logic [CH*BR-1:0] m_levels();
      logic [CH*BR-1:0] v;
      for (int i = 0; i < CH; i++) v[i*BR +: BR] = BR'(m_cur[i]);
      return v;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("ack", ack, m_ack);
      check("rdat", dat_o, m_dat);
      check("level", pdm_dat, m_levels());
      check("pstb", pdm_stb, m_stb);
      check("irq", irq, (m_done != 0) && (m_ie != 0));
      check("stall", stall, 0);
   endtask

   task automatic bus(input bit w, input int a, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = w; adr = 4'(a); dat = d;
      tick();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int guard;
      model_reset();
      #2;
      rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd2; dat = 32'hFF;
      repeat (3) tick();
      check("rst_ack", ack, 0);
      check("rst_lvl", pdm_dat, 0);
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick();
      for (int a = 0; a < 16; a++) begin
         bus(0, a, 0);
         check("rst_reg", dat_o, 0);
      end

      bus(1, 2, 32'hFFFF_FFA5);
      bus(0, 2, 0);
      check("rd_a5", dat_o, 32'hA5);
      bus(1, 12, 32'h1234);
      bus(0, 12, 0);
      check("rd_unmap", dat_o, 0);
      bus(1, 2, 0);

      bus(1, 9, 3);
      bus(1, 10, 32'h40);
      bus(1, 0, 32'hF0);
      bus(1, 8, 1);
      idle(40);
      check("ramp_up", pdm_dat[7:0], 8'hF0);

      bus(1, 10, 32'h50);
      bus(1, 0, 32'h10);
      idle(40);
      check("ramp_dn", pdm_dat[7:0], 8'h10);
      bus(1, 10, 0);
      bus(1, 0, 32'h33);
      idle(20);
      check("jump", pdm_dat[7:0], 8'h33);

      bus(1, 8, 0);
      idle(10);
      bus(1, 0, 32'h11);
      bus(1, 1, 32'h22);
      bus(1, 2, 32'h33);
      bus(1, 3, 32'h44);
      bus(1, 8, 1);
      guard = 0;
      while (pdm_stb !== 4'b0001 && guard < 50) begin
         tick();
         guard++;
      end
      check("rr_s0", pdm_stb, 4'b0001);
      bus(1, 8, 0);
      check("rr_s1", pdm_stb, 4'b0010);
      tick();
      check("rr_s2", pdm_stb, 4'b0100);
      tick();
      check("rr_s3", pdm_stb, 4'b1000);
      idle(30);
      check("rr_lvl", pdm_dat, 32'h4433_2211);

      bus(1, 8, 3);
      bus(1, 0, 32'h80);
      idle(30);
      check("irq_set", irq, IRQ);
      bus(1, 11, 32'h8000_0000);
      check("irq_clr", irq, 0);
      idle(5);

      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 599) != 0);
         cyc = 1'($urandom_range(0, 1));
         stb = ($urandom_range(0, 2) == 0);
         we  = 1'($urandom_range(0, 1));
         adr = 4'($urandom_range(0, 15));
         dat = $urandom();
         if (adr == 4'd9) dat = $urandom_range(0, 6);
         if (adr == 4'd10 && $urandom_range(0, 3) == 0) dat = 0;
         if (adr == 4'd8) dat[0] = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_pdm_ctrl.md
Name: wb_pdm_ctrl

Overview:
- Wishbone B4 pipelined slave that owns a bank of PDM channel levels and sequences their updates.
- Each channel has a software-written target. A prescaled tick starts a round-robin sweep, in which one shared ramp adder slews each channel's current level toward its target by STEP, one channel per cycle.
- Outputs drive a row of wb_pdm_channel instances: level bus plus a per-channel load strobe.

Parameters:
- CHANNELS, 4, number of PDM channels (1..8).
- BIT_RESOLUTION, 8, level width per channel (1..16).
- PRESCALER_WIDTH, 16, width of the PRESCALE register and its counter.

Ports:
- wb_clk_i  input  1  single clock.
- wb_rst_ni  input  1  synchronous reset, active-low.
- wb_cyc_i  input  1  bus cycle.
- wb_stb_i  input  1  strobe.
- wb_we_i  input  1  write enable.
- wb_adr_i  input  4  word address.
- wb_dat_i  input  32  write data.
- wb_dat_o  output  32  read data.
- wb_ack_o  output  1  acknowledge.
- wb_stall_o  output  1  stall, tied 0.
- pdm_dat_o  output  CHANNELS*BIT_RESOLUTION  current levels; channel i occupies slice [i*BIT_RESOLUTION +: BIT_RESOLUTION].
- pdm_stb_o  output  CHANNELS  one-cycle load pulse per channel.
- irq_o  output  1  settle interrupt (see Optional Feature).

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge) clears all state: TARGET[], current[], CTRL, PRESCALE, STEP, counter, sweep index and DONE. State returns to IDLE. All outputs are 0. Reset overrides everything, including mid-sweep and mid-transfer.
- Register map (word address):
  - 0..CHANNELS-1: TARGET[i], RW, bits [BIT_RESOLUTION-1:0].
  - 8: CTRL, RW, bit0 = EN.
  - 9: PRESCALE, RW.
  - 10: STEP, RW, BIT_RESOLUTION bits.
  - 11: STATUS, RO, bits [CHANNELS-1:0] = BUSY (current != target), bit 31 = DONE.
- Register access:
  - Unmapped reads return 0; unmapped writes are ignored.
  - Unused register bits read 0.
- Bus handshake:
  - wb_ack_o asserts exactly one cycle after each cycle with wb_cyc_i & wb_stb_i.
  - Back-to-back strobes get back-to-back acks.
  - wb_dat_o is valid in the ack cycle; it is 0 when ack is low.
  - A write lands in its register on the strobe edge.
- FSM states: IDLE and SWEEP.
  - IDLE, EN=1: the counter decrements each cycle. When it reads 0 it reloads PRESCALE and the FSM enters SWEEP with index=0.
  - IDLE, EN=0: the counter holds and no sweep starts.
  - SWEEP: services channel index each cycle, then index increments. After channel CHANNELS-1 the FSM returns to IDLE.
  - The counter does not run during SWEEP. Effective tick period is PRESCALE+1+CHANNELS cycles.
  - Clearing EN mid-sweep does not abort: the sweep completes and the FSM then idles.
- Service of channel k, using the target value at that cycle:
  - current < target: current = min(current+STEP, target), computed in BIT_RESOLUTION+1 bits so there is no wrap.
  - current > target: current = max(current-STEP, target), computed signed so there is no underflow.
  - STEP=0: current = target (jump).
  - current == target: no change and no strobe.
  - When current changes, the new value appears on pdm_dat_o and pdm_stb_o[k]=1 for one cycle, both on the edge ending the service cycle.
- Sweep timing: if the FSM enters SWEEP at edge t, channel k's update is visible after edge t+1+k.
- TARGET write during SWEEP:
  - Affects channel k if it lands at or before k's service edge.
  - Otherwise takes effect on the next sweep.
- BUSY is combinational from current vs target.

Optional Feature:
- Macro: WB_PDM_CTRL_IRQ_EN.
- With the macro defined:
  - DONE sets when a sweep ends with all BUSY bits 0, provided at least one strobe fired in that sweep.
  - Writing STATUS with bit 31 = 1 clears DONE.
  - If set and clear coincide, the set wins.
  - irq_o = DONE & CTRL bit1 (IRQ enable, RW).
- Without the macro:
  - DONE reads 0 and irq_o is tied 0.
  - CTRL bit1 reads 0 and ignores writes.

Test Plan:
- Reset: hold wb_rst_ni=0 for 3 cycles with strobes active -> no ack; pdm_dat_o=0, pdm_stb_o=0, all registers read 0.
- Bus: write TARGET[2]=0xA5, then read it back-to-back -> acks in consecutive cycles, read data 0x000000A5. Read address 12 -> 0. Write address 12 -> no state change.
- Ramp up: PRESCALE=3, STEP=0x40, TARGET[0]=0xF0, EN=1 -> channel 0 takes 0x40, 0x80, 0xC0, 0xF0 on successive sweeps. Tick spacing is 8 cycles; one strobe per change; no strobe after reaching 0xF0.
- Ramp down / jump: from 0xF0 with TARGET=0x10 and STEP=0x50 -> 0xA0, 0x50, 0x10, with no underflow. STEP=0, TARGET=0x33 -> single strobe to 0x33.
- Round-robin: all 4 TARGETs differ from current -> in one sweep, pdm_stb_o pulses 0001, 0010, 0100, 1000 on consecutive cycles. EN cleared mid-sweep -> the remaining channels are still served, then no further sweeps.
- IRQ (macro on): CTRL=0x3, settle all channels -> DONE and irq_o=1. Write STATUS=0x80000000 -> irq_o=0 next cycle. Macro off -> irq_o stays 0.
